stage_memory: RTL and testbench

STAGE_MEMORY -- requirements
Module: stage_memory

---
 rtl/stage_memory_if.sv | 13 +
 rtl/stage_memory.sv | 196 +++++++++++++++++++
 tb/tb_stage_memory.sv | 397 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/stage_memory_if.sv
// Data-memory port of the MEM stage: a 32-bit request/ready handshake.
// The stage is the master; the memory (or a bench model) is the slave.
interface stage_memory_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ready;
    logic [31:0] rdata;

    modport master (output req, we, addr, wdata, input ready, rdata);
    modport slave  (input req, we, addr, wdata, output ready, rdata);
endinterface

// File: rtl/stage_memory.sv
// MEM pipeline stage: turns scalar/vector loads and stores into 32-bit
// memory beats, assembles vector read data lane by lane, stalls upstream
// while an access is in flight and drives the MEM/WB pipeline register.
module stage_memory (
    input  logic                  clk,
    input  logic                  rst,
    // EX/MEM control and data
    input  logic                  mem_valid,
    input  logic                  mem_reg_write,
    input  logic [4:0]            mem_rd,
    input  logic [1:0]            mem_result_src,
    input  logic                  mem_mem_write,
    input  logic                  mem_vector_op,
    input  logic [127:0]          mem_alu_result,
    input  logic [127:0]          mem_write_data,
    input  logic [31:0]           mem_pc_plus_4,
    input  logic [127:0]          mem_imm_ext,
    // Data-memory port
    stage_memory_if.master        dmem,
    // Upstream hold
    output logic                  mem_stall,
    // MEM/WB register
    output logic                  wb_valid,
    output logic                  wb_reg_write,
    output logic [4:0]            wb_rd,
    output logic [1:0]            wb_result_src,
    output logic                  wb_vector_op,
    output logic [127:0]          wb_alu_result,
    output logic [127:0]          wb_read_result,
    output logic [31:0]           wb_pc_plus_4,
    output logic [127:0]          wb_imm_ext
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    // Operation captured when a memory op is accepted; drives every beat.
    typedef struct packed {
        logic         reg_write;
        logic [4:0]   rd;
        logic [1:0]   result_src;
        logic         mem_write;
        logic         vector_op;
        logic [127:0] alu_result;
        logic [127:0] write_data;
        logic [31:0]  pc_plus_4;
        logic [127:0] imm_ext;
    } op_t;

    typedef struct packed {
        logic         valid;
        logic         reg_write;
        logic [4:0]   rd;
        logic [1:0]   result_src;
        logic         vector_op;
        logic [127:0] alu_result;
        logic [127:0] read_result;
        logic [31:0]  pc_plus_4;
        logic [127:0] imm_ext;
    } wb_t;

    state_t       state_q, state_d;
    logic [1:0]   beat_q, beat_d;
    logic [127:0] buf_q, buf_d;
    op_t          op_q, op_d;
    wb_t          wb_q, wb_d;

    logic         is_mem_op;
    logic         last_beat;
    logic         is_load;
    logic [6:0]   lane_lsb;
    logic [127:0] assembled;

    assign is_mem_op = mem_valid && ((mem_result_src == 2'b01) || mem_mem_write);
    assign last_beat = op_q.vector_op ? (beat_q == 2'd3) : (beat_q == 2'd0);
    assign is_load   = !op_q.mem_write;
    assign lane_lsb  = {beat_q, 5'b00000};

    // Read buffer with the word returned for the current beat merged into its lane.
    always_comb begin
        assembled                = buf_q;
        assembled[lane_lsb +: 32] = dmem.rdata;
    end

    // Next-state, beat sequencing, memory port drive and MEM/WB next value.
    always_comb begin
        // NOTE: every signal gets a default before any branch so no path leaves one unassigned (no latches).
        state_d    = state_q;
        beat_d     = beat_q;
        buf_d      = buf_q;
        op_d       = op_q;
        wb_d       = '0;
        mem_stall  = 1'b0;
        dmem.req   = 1'b0;
        dmem.we    = 1'b0;
        dmem.addr  = '0;
        dmem.wdata = '0;

        // While reset is high everything stays at its zero default.
        if (!rst) begin
            case (state_q)
                IDLE: begin
                    if (is_mem_op) begin
                        mem_stall       = 1'b1;
                        op_d.reg_write  = mem_reg_write;
                        op_d.rd         = mem_rd;
                        op_d.result_src = mem_result_src;
                        op_d.mem_write  = mem_mem_write;
                        op_d.vector_op  = mem_vector_op;
                        op_d.alu_result = mem_alu_result;
                        op_d.write_data = mem_write_data;
                        op_d.pc_plus_4  = mem_pc_plus_4;
                        op_d.imm_ext    = mem_imm_ext;
                        beat_d          = 2'd0;
                        buf_d           = '0;
                        state_d         = ACCESS;
                    end else if (mem_valid) begin
                        wb_d.valid      = 1'b1;
                        wb_d.reg_write  = mem_reg_write;
                        wb_d.rd         = mem_rd;
                        wb_d.result_src = mem_result_src;
                        wb_d.vector_op  = mem_vector_op;
                        wb_d.alu_result = mem_alu_result;
                        wb_d.pc_plus_4  = mem_pc_plus_4;
                        wb_d.imm_ext    = mem_imm_ext;
                    end
                end

                ACCESS: begin
                    dmem.req   = 1'b1;
                    dmem.we    = op_q.mem_write;
                    dmem.addr  = op_q.alu_result[31:0] + {28'd0, beat_q, 2'b00};
                    dmem.wdata = op_q.write_data[lane_lsb +: 32];
                    mem_stall  = !(dmem.ready && last_beat);

                    if (dmem.ready) begin
                        beat_d = beat_q + 2'd1;
                        if (is_load) begin
                            buf_d = assembled;
                        end
                        if (last_beat) begin
                            state_d          = IDLE;
                            beat_d           = 2'd0;
                            wb_d.valid       = 1'b1;
                            wb_d.reg_write   = op_q.reg_write;
                            wb_d.rd          = op_q.rd;
                            wb_d.result_src  = op_q.result_src;
                            wb_d.vector_op   = op_q.vector_op;
                            wb_d.alu_result  = op_q.alu_result;
                            wb_d.read_result = is_load ? assembled : '0;
                            wb_d.pc_plus_4   = op_q.pc_plus_4;
                            wb_d.imm_ext     = op_q.imm_ext;
                        end
                    end
                end

                default: state_d = IDLE;
            endcase
        end
    end

    // Control state, read buffer and MEM/WB register; synchronous reset clears them all.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            beat_q  <= 2'd0;
            buf_q   <= '0;
            wb_q    <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
            state_q <= state_d;
            beat_q  <= beat_d;
            buf_q   <= buf_d;
            wb_q    <= wb_d;
        end
    end

    // Captured operation fields.
    // NOTE: no reset here: these are only read in ACCESS, which is always entered through a fresh capture.
    always_ff @(posedge clk) begin
        op_q <= op_d;
    end

    assign wb_valid       = wb_q.valid;
    assign wb_reg_write   = wb_q.reg_write;
    assign wb_rd          = wb_q.rd;
    assign wb_result_src  = wb_q.result_src;
    assign wb_vector_op   = wb_q.vector_op;
    assign wb_alu_result  = wb_q.alu_result;
    assign wb_read_result = wb_q.read_result;
    assign wb_pc_plus_4   = wb_q.pc_plus_4;
    assign wb_imm_ext     = wb_q.imm_ext;

endmodule

// File: tb/tb_stage_memory.sv
// Self-checking bench for stage_memory: a table of single-cycle IDLE vectors,
// hand-written multi-cycle access sequences, and a randomized run checked
// against a transaction-level model (expected beats and MEM/WB records).
module tb_stage_memory;

    logic         clk = 1'b0;
    logic         rst;
    logic         mem_valid, mem_reg_write, mem_mem_write, mem_vector_op;
    logic [4:0]   mem_rd;
    logic [1:0]   mem_result_src;
    logic [127:0] mem_alu_result, mem_write_data, mem_imm_ext;
    logic [31:0]  mem_pc_plus_4;
    logic         mem_stall;
    logic         wb_valid, wb_reg_write, wb_vector_op;
    logic [4:0]   wb_rd;
    logic [1:0]   wb_result_src;
    logic [127:0] wb_alu_result, wb_read_result, wb_imm_ext;
    logic [31:0]  wb_pc_plus_4;

    stage_memory_if dmem ();

    always #5 clk = ~clk;

    stage_memory dut (
        .clk            (clk),
        .rst            (rst),
        .mem_valid      (mem_valid),
        .mem_reg_write  (mem_reg_write),
        .mem_rd         (mem_rd),
        .mem_result_src (mem_result_src),
        .mem_mem_write  (mem_mem_write),
        .mem_vector_op  (mem_vector_op),
        .mem_alu_result (mem_alu_result),
        .mem_write_data (mem_write_data),
        .mem_pc_plus_4  (mem_pc_plus_4),
        .mem_imm_ext    (mem_imm_ext),
        .dmem           (dmem),
        .mem_stall      (mem_stall),
        .wb_valid       (wb_valid),
        .wb_reg_write   (wb_reg_write),
        .wb_rd          (wb_rd),
        .wb_result_src  (wb_result_src),
        .wb_vector_op   (wb_vector_op),
        .wb_alu_result  (wb_alu_result),
        .wb_read_result (wb_read_result),
        .wb_pc_plus_4   (wb_pc_plus_4),
        .wb_imm_ext     (wb_imm_ext)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_op(input logic v, input logic rw, input logic [4:0] rd, input logic [1:0] src,
                          input logic mw, input logic vop, input logic [127:0] alu,
                          input logic [127:0] wd, input logic [31:0] pc, input logic [127:0] imm);
        mem_valid      = v;
        mem_reg_write  = rw;
        mem_rd         = rd;
        mem_result_src = src;
        mem_mem_write  = mw;
        mem_vector_op  = vop;
        mem_alu_result = alu;
        mem_write_data = wd;
        mem_pc_plus_4  = pc;
        mem_imm_ext    = imm;
    endtask

    task automatic idle_inputs();
        set_op(1'b0, 1'b0, 5'd0, 2'b00, 1'b0, 1'b0, '0, '0, '0, '0);
    endtask

    task automatic check_wb_zero(input string tag);
        check({tag, "_wb_valid"}, wb_valid, 0);
        check({tag, "_wb_ctrl"}, {wb_reg_write, wb_rd, wb_result_src, wb_vector_op}, 0);
        check({tag, "_wb_alu"}, wb_alu_result, 0);
        check({tag, "_wb_read"}, wb_read_result, 0);
        check({tag, "_wb_pc_imm"}, wb_pc_plus_4 | wb_imm_ext, 0);
    endtask

    // ---------------- table vectors (IDLE-state behaviour) ----------------
    typedef struct {
        logic         valid;
        logic         rw;
        logic [4:0]   rd;
        logic [1:0]   src;
        logic         mw;
        logic         vop;
        logic [127:0] alu;
        logic [31:0]  pc;
        logic [127:0] imm;
        logic         ready;
        logic         exp_stall;
        logic         exp_wbv;
    } vec_t;

    vec_t vecs[6];

    // ---------------- transaction-level model ----------------
    typedef struct {
        logic         we;
        logic [31:0]  addr;
        logic [31:0]  wdata;
    } beat_t;

    typedef struct {
        logic         valid;
        logic         rw;
        logic [4:0]   rd;
        logic [1:0]   src;
        logic         vop;
        logic [127:0] alu;
        logic [127:0] rr;
        logic [31:0]  pc;
        logic [127:0] imm;
    } wb_exp_t;

    logic [31:0] mem_model [logic [31:0]];
    beat_t       beats[$];
    wb_exp_t     cur;

    function automatic logic [31:0] mem_rd_word(input logic [31:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return a ^ 32'h5EED_1234;
    endfunction

    logic [31:0]  lanes [4];
    logic [31:0]  exp_addrs [4];
    int           seq_beat [6];
    logic         seq_rdy [6];
    logic [31:0]  r32;
    logic [31:0]  base;
    logic [127:0] exp_rr;
    beat_t        bt;
    bit           pending;
    bit           consumed;
    int           ops_done;
    int           cycles;
    int           kind;

    task automatic gen_op();
        int cnt;
        kind = int'($urandom_range(0, 5));
        r32 = $urandom;
        mem_valid      = (kind != 0);
        mem_reg_write  = r32[0];
        mem_rd         = r32[5:1];
        mem_alu_result = {$urandom, $urandom, $urandom, $urandom};
        mem_write_data = {$urandom, $urandom, $urandom, $urandom};
        mem_imm_ext    = {$urandom, $urandom, $urandom, $urandom};
        mem_pc_plus_4  = $urandom;
        mem_mem_write  = (kind == 3 || kind == 5) ? 1'b1 : (kind == 0 ? r32[6] : 1'b0);
        mem_vector_op  = (kind == 4 || kind == 5) ? 1'b1 : (kind <= 1 ? r32[7] : 1'b0);
        if (kind == 2 || kind == 4)      mem_result_src = 2'b01;
        else if (kind == 0)              mem_result_src = r32[9:8];
        else                             mem_result_src = (r32[9:8] == 2'b01) ? 2'b10 : r32[9:8];
        if (kind >= 2) begin
            if ($urandom_range(0, 3) == 0) base = 32'hFFFF_FFF0 + 32'($urandom_range(0, 3) * 4);
            else                           base = 32'h0000_0100 + 32'($urandom_range(0, 15) * 4);
            mem_alu_result[31:0] = base;
        end

        cur.valid = (kind != 0);
        cur.rw    = mem_reg_write;
        cur.rd    = mem_rd;
        cur.src   = mem_result_src;
        cur.vop   = mem_vector_op;
        cur.alu   = mem_alu_result;
        cur.pc    = mem_pc_plus_4;
        cur.imm   = mem_imm_ext;
        cur.rr    = '0;
        beats.delete();
        if (kind >= 2) begin
            cnt = mem_vector_op ? 4 : 1;
            for (int i = 0; i < cnt; i++) begin
                bt.we    = mem_mem_write;
                bt.addr  = base + 32'(4 * i);
                bt.wdata = mem_write_data[32*i +: 32];
                beats.push_back(bt);
                if (mem_mem_write) mem_model[bt.addr] = bt.wdata;
                else               cur.rr[32*i +: 32] = mem_rd_word(bt.addr);
            end
        end
    endtask

    initial begin
        vecs[0] = '{1'b1, 1'b1, 5'd3,  2'b00, 1'b0, 1'b0, 128'h5,                    32'h0000_1004, 128'h7,  1'b0, 1'b0, 1'b1};
        vecs[1] = '{1'b1, 1'b1, 5'd31, 2'b10, 1'b0, 1'b1, {4{32'hCAFE_F00D}},       32'hFFFF_FFFC, 128'h1,  1'b1, 1'b0, 1'b1};
        vecs[2] = '{1'b1, 1'b0, 5'd0,  2'b11, 1'b0, 1'b0, 128'h1234_5678_9ABC,      32'h0000_0040, {4{32'h8000_0001}}, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{1'b0, 1'b1, 5'd9,  2'b01, 1'b0, 1'b1, 128'h100,                 32'h0000_0200, 128'h3,  1'b1, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 5'd12, 2'b00, 1'b1, 1'b0, 128'h200,                 32'h0000_0300, 128'h4,  1'b1, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 1'b1, 5'd31, 2'b11, 1'b1, 1'b1, {128{1'b1}},              32'hFFFF_FFFF, {128{1'b1}}, 1'b0, 1'b0, 1'b0};

        // ---------------- reset: dominates a memory op and dmem_ready ----------------
        rst = 1'b1;
        set_op(1'b1, 1'b1, 5'd4, 2'b01, 1'b0, 1'b1, 128'h100, '0, 32'h10, '0);
        dmem.ready = 1'b1;
        dmem.rdata = 32'h1111_2222;
        @(negedge clk);
        #1;
        check("rst_stall", mem_stall, 0);
        check("rst_req", dmem.req, 0);
        step();
        check_wb_zero("rst");
        idle_inputs();
        dmem.ready = 1'b0;
        rst = 1'b0;
        step();
        check("post_rst_req", dmem.req, 0);

        // ---------------- table vectors ----------------
        for (int i = 0; i < 6; i++) begin
            set_op(vecs[i].valid, vecs[i].rw, vecs[i].rd, vecs[i].src, vecs[i].mw, vecs[i].vop,
                   vecs[i].alu, {4{32'h0BAD_0BAD}}, vecs[i].pc, vecs[i].imm);
            dmem.ready = vecs[i].ready;
            #1;
            check($sformatf("vec%0d_stall", i), mem_stall, vecs[i].exp_stall);
            check($sformatf("vec%0d_req", i), dmem.req, 0);
            step();
            check($sformatf("vec%0d_wb_valid", i), wb_valid, vecs[i].exp_wbv);
            check($sformatf("vec%0d_wb_ctrl", i), {wb_reg_write, wb_rd, wb_result_src, wb_vector_op},
                  vecs[i].exp_wbv ? {vecs[i].rw, vecs[i].rd, vecs[i].src, vecs[i].vop} : 9'd0);
            check($sformatf("vec%0d_wb_alu", i), wb_alu_result, vecs[i].exp_wbv ? vecs[i].alu : 128'd0);
            check($sformatf("vec%0d_wb_read", i), wb_read_result, 0);
            check($sformatf("vec%0d_wb_pc", i), wb_pc_plus_4, vecs[i].exp_wbv ? vecs[i].pc : 32'd0);
            check($sformatf("vec%0d_wb_imm", i), wb_imm_ext, vecs[i].exp_wbv ? vecs[i].imm : 128'd0);
        end
        idle_inputs();
        dmem.ready = 1'b0;
        step();

        // ---------------- scalar load, ready on first ACCESS cycle ----------------
        set_op(1'b1, 1'b1, 5'd7, 2'b01, 1'b0, 1'b0, 128'h100, '0, 32'h0000_2000, 128'h9);
        #1;
        check("sld_accept_stall", mem_stall, 1);
        check("sld_accept_req", dmem.req, 0);
        step();
        dmem.ready = 1'b1;
        dmem.rdata = 32'hDEAD_BEEF;
        #1;
        check("sld_req", dmem.req, 1);
        check("sld_addr", dmem.addr, 32'h100);
        check("sld_we", dmem.we, 0);
        check("sld_final_stall", mem_stall, 0);
        check("sld_bubble", wb_valid, 0);
        step();
        idle_inputs();
        dmem.ready = 1'b0;
        check("sld_wb_valid", wb_valid, 1);
        check("sld_wb_read", wb_read_result, {96'd0, 32'hDEAD_BEEF});
        check("sld_wb_ctrl", {wb_reg_write, wb_rd, wb_result_src, wb_vector_op}, {1'b1, 5'd7, 2'b01, 1'b0});
        check("sld_wb_pc", wb_pc_plus_4, 32'h0000_2000);
        #1;
        check("sld_idle_req", dmem.req, 0);

        // ---------------- vector store with wait states on beat 1 ----------------
        lanes = '{32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003, 32'hDDDD_0004};
        set_op(1'b1, 1'b0, 5'd2, 2'b00, 1'b1, 1'b1, 128'h200,
               {lanes[3], lanes[2], lanes[1], lanes[0]}, 32'h0000_3000, '0);
        #1;
        check("vst_accept_stall", mem_stall, 1);
        step();
        idle_inputs();
        seq_beat = '{0, 1, 1, 1, 2, 3};
        seq_rdy  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        for (int k = 0; k < 6; k++) begin
            dmem.ready = seq_rdy[k];
            #1;
            check($sformatf("vst%0d_req", k), dmem.req, 1);
            check($sformatf("vst%0d_we", k), dmem.we, 1);
            check($sformatf("vst%0d_addr", k), dmem.addr, 32'h200 + 32'(4 * seq_beat[k]));
            check($sformatf("vst%0d_wdata", k), dmem.wdata, lanes[seq_beat[k]]);
            check($sformatf("vst%0d_stall", k), mem_stall, !(seq_beat[k] == 3 && seq_rdy[k]));
            check($sformatf("vst%0d_bubble", k), wb_valid, 0);
            step();
        end
        dmem.ready = 1'b0;
        check("vst_wb_valid", wb_valid, 1);
        check("vst_wb_read", wb_read_result, 0);
        check("vst_wb_ctrl", {wb_reg_write, wb_rd, wb_vector_op}, {1'b0, 5'd2, 1'b1});
        step();
        check("vst_single_pulse", wb_valid, 0);

        // ---------------- vector load wrapping past 2^32 ----------------
        lanes     = '{32'h0101_0101, 32'h2222_3333, 32'h4444_5555, 32'h6666_7777};
        exp_addrs = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
        set_op(1'b1, 1'b1, 5'd10, 2'b01, 1'b0, 1'b1, 128'hFFFF_FFF8, '0, 32'h0000_4000, 128'h5);
        step();
        idle_inputs();
        for (int b = 0; b < 4; b++) begin
            dmem.ready = 1'b1;
            dmem.rdata = lanes[b];
            #1;
            check($sformatf("vld%0d_addr", b), dmem.addr, exp_addrs[b]);
            check($sformatf("vld%0d_stall", b), mem_stall, (b != 3));
            step();
        end
        dmem.ready = 1'b0;
        check("vld_wb_valid", wb_valid, 1);
        check("vld_wb_read", wb_read_result, {lanes[3], lanes[2], lanes[1], lanes[0]});
        check("vld_wb_vop", wb_vector_op, 1);
        step();

        // ---------------- reset during beat 2 of a vector load ----------------
        set_op(1'b1, 1'b1, 5'd11, 2'b01, 1'b0, 1'b1, 128'h300, '0, 32'h0000_5000, '0);
        step();
        idle_inputs();
        for (int b = 0; b < 2; b++) begin
            dmem.ready = 1'b1;
            dmem.rdata = 32'h7777_0000 + 32'(b);
            step();
        end
        rst = 1'b1;
        dmem.ready = 1'b1;
        #1;
        check("rstmid_stall", mem_stall, 0);
        check("rstmid_req", dmem.req, 0);
        step();
        rst = 1'b0;
        dmem.ready = 1'b1;
        check_wb_zero("rstmid");
        #1;
        check("rstmid_idle_req", dmem.req, 0);
        step();
        check("rstmid_no_write", wb_valid, 0);
        set_op(1'b1, 1'b1, 5'd9, 2'b00, 1'b0, 1'b0, 128'h42, '0, 32'h0000_6000, '0);
        dmem.ready = 1'b0;
        #1;
        check("rstmid_alu_stall", mem_stall, 0);
        step();
        check("rstmid_alu_valid", wb_valid, 1);
        check("rstmid_alu_result", wb_alu_result, 128'h42);
        check("rstmid_alu_rd", wb_rd, 5'd9);
        idle_inputs();

        // ---------------- randomized run against the transaction model ----------------
        pending  = 1'b0;
        ops_done = 0;
        cycles   = 0;
        while (ops_done < 300 && cycles < 20000) begin
            if (!pending) begin
                gen_op();
                pending = 1'b1;
            end
            dmem.ready = ($urandom_range(0, 3) != 0);
            dmem.rdata = dmem.req ? mem_rd_word(dmem.addr) : $urandom;
            #1;
            if (dmem.req && dmem.ready) begin
                if (beats.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL rnd_extra_beat: got beat at addr %h, expected none", dmem.addr);
                end else begin
                    bt = beats.pop_front();
                    check("rnd_beat", {dmem.we, dmem.addr, dmem.wdata}, {bt.we, bt.addr, bt.wdata});
                end
            end
            consumed = !mem_stall;
            step();
            cycles++;
            check("rnd_wb_valid", wb_valid, consumed && cur.valid);
            if (consumed) begin
                if (cur.valid) begin
                    check("rnd_wb_ctrl", {wb_reg_write, wb_rd, wb_result_src, wb_vector_op},
                          {cur.rw, cur.rd, cur.src, cur.vop});
                    check("rnd_wb_alu", wb_alu_result, cur.alu);
                    check("rnd_wb_read", wb_read_result, cur.rr);
                    check("rnd_wb_pc", wb_pc_plus_4, cur.pc);
                    check("rnd_wb_imm", wb_imm_ext, cur.imm);
                end
                check("rnd_beats_left", beats.size(), 0);
                pending = 1'b0;
                ops_done++;
            end
            if (!wb_valid) begin
                check("rnd_bubble_fields", wb_alu_result | {127'd0, wb_reg_write}, 0);
            end
        end
        check("rnd_ops_done", ops_done, 300);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
